// File: rtl/rx_burst_pkg.sv
// Shared definitions for the rx_burst receiver: FSM encoding, default
// parameter values and the word-index width.
package rx_burst_pkg;

    // Default data word width
    localparam int DEFAULT_DATA_W    = 32;
    // Default number of words in one burst
    localparam int DEFAULT_BURST_LEN = 7;
    // Default FIFO depth
    localparam int DEFAULT_DEPTH     = 8;
    // Word index width; covers the largest allowed burst length
    localparam int IDX_W             = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_t;

    // Value the word at position idx must carry: idx+1, zero-extended
    function automatic logic [31:0] expected_word(input logic [IDX_W-1:0] idx);
        return {{(32-IDX_W){1'b0}}, idx} + 32'd1;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Parameterised synchronous FIFO. Read data is the head entry, presented
// combinationally; a pushed word becomes visible the cycle after the push.
module rx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Guard against overflow/underflow even if the caller misbehaves
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == {(AW+1){1'b0}});
    assign count = count_r;

endmodule

// File: rtl/rx_burst.sv
// Burst receiver: accepts fixed-length bursts, checks each word against
// its position in the burst, keeps per-burst statistics and replays the
// accepted words through a FIFO on a downstream valid/ready port.
module rx_burst
    import rx_burst_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              burst_done,
    output logic              seq_err,
    output logic [15:0]       burst_cnt,
    output logic [DATA_W-1:0] sum
);

    localparam int CW = $clog2(DEPTH) + 1;

    rx_state_t         state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] sum_r;
    logic [15:0]       burst_cnt_r;
    logic              seq_err_r;
    logic              burst_done_r;

    logic              in_xfer_s;
    logic              pop_s;
    logic              last_word_s;
    logic              word_bad_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic [31:0]       exp_word_s;

    // ready depends only on reset, occupancy and state, never on valid
    assign ready       = !rst && !fifo_full_s && (state_r != DONE);
    assign in_xfer_s   = valid && ready;
    assign out_valid   = (fifo_count_s != {CW{1'b0}});
    assign pop_s       = out_ready && !fifo_empty_s;
    assign last_word_s = (state_r == RECV) && (idx_r == IDX_W'(BURST_LEN - 1));
    // Expected value comes from the index, so one bad word cannot cascade
    assign exp_word_s  = expected_word(idx_r);
    assign word_bad_s  = (data != DATA_W'(exp_word_s));

    rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_xfer_s),
        .din   (data),
        .pop   (pop_s),
        .dout  (out_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Burst FSM, sequence checker and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= {IDX_W{1'b0}};
            acc_r        <= {DATA_W{1'b0}};
            sum_r        <= {DATA_W{1'b0}};
            burst_cnt_r  <= 16'd0;
            seq_err_r    <= 1'b0;
            burst_done_r <= 1'b0;
        end else begin
            burst_done_r <= 1'b0;
            if (in_xfer_s && word_bad_s) begin
                seq_err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (in_xfer_s) begin
                        state_r <= RECV;
                        idx_r   <= IDX_W'(1);
                        acc_r   <= acc_r + data;
                    end
                end
                RECV: begin
                    if (in_xfer_s) begin
                        if (last_word_s) begin
                            state_r      <= DONE;
                            idx_r        <= {IDX_W{1'b0}};
                            sum_r        <= acc_r + data;
                            acc_r        <= {DATA_W{1'b0}};
                            burst_cnt_r  <= burst_cnt_r + 16'd1;
                            burst_done_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                            acc_r <= acc_r + data;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign burst_done = burst_done_r;
    assign seq_err    = seq_err_r;
    assign burst_cnt  = burst_cnt_r;
    assign sum        = sum_r;

endmodule

// File: tb/tb_rx_burst.sv
// Self-checking bench for rx_burst: directed scenarios plus randomized
// traffic compared against a transaction-level model (word queue, burst
// position counter, running sums).
module tb_rx_burst;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int BURST_LEN = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data = '0;
    logic              valid = 1'b0;
    logic              ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              burst_done;
    logic              seq_err;
    logic [15:0]       burst_cnt;
    logic [DATA_W-1:0] sum;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    int                m_pos;
    logic [DATA_W-1:0] m_acc;
    logic [DATA_W-1:0] m_sum;
    logic [15:0]       m_cnt;
    bit                m_err;
    bit                m_done;
    bit                last_acc;

    rx_burst #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .burst_done (burst_done),
        .seq_err    (seq_err),
        .burst_cnt  (burst_cnt),
        .sum        (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic bit m_ready();
        return !rst && !m_done && (m_q.size() < DEPTH);
    endfunction

    task automatic check_outputs();
        check("ready", 32'(ready), 32'(m_ready()));
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
        check("burst_done", 32'(burst_done), 32'(m_done));
        check("seq_err", 32'(seq_err), 32'(m_err));
        check("burst_cnt", 32'(burst_cnt), 32'(m_cnt));
        check("sum", sum, m_sum);
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit ordy);
        bit in_x;
        bit out_x;
        check_outputs();
        valid = v; data = d; out_ready = ordy;
        in_x  = v && m_ready();
        out_x = (m_q.size() != 0) && ordy;
        last_acc = in_x;
        if (out_x) void'(m_q.pop_front());
        m_done = 1'b0;
        if (in_x) begin
            m_q.push_back(d);
            if (d != DATA_W'(m_pos + 1)) m_err = 1'b1;
            m_acc = m_acc + d;
            m_pos++;
            if (m_pos == BURST_LEN) begin
                m_sum  = m_acc;
                m_acc  = '0;
                m_pos  = 0;
                m_cnt  = m_cnt + 16'd1;
                m_done = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold a word on the input until accepted, bounded
    task automatic send_word(input logic [DATA_W-1:0] d, input bit ordy);
        int n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 40) begin
            cycle(1'b1, d, ordy);
            n++;
        end
        check("send_accept", 32'(last_acc), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; out_ready = 1'b0; data = '0;
        @(posedge clk);
        @(negedge clk);
        m_q.delete();
        m_pos = 0; m_acc = '0; m_sum = '0; m_cnt = 16'd0;
        m_err = 1'b0; m_done = 1'b0;
        check_outputs();
        check("rst_ready_low", 32'(ready), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 3; i++) cycle(1'b0, '0, 1'b1);
        check("drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] bad [7];
        int guard;
        bad[0] = 32'd1; bad[1] = 32'd2; bad[2] = 32'd4; bad[3] = 32'd4;
        bad[4] = 32'd5; bad[5] = 32'd6; bad[6] = 32'd7;

        // Clean burst
        do_reset();
        for (int w = 1; w <= BURST_LEN; w++) send_word(DATA_W'(w), 1'b1);
        check("clean_sum", sum, 32'd28);
        check("clean_cnt", 32'(burst_cnt), 32'd1);
        check("clean_done", 32'(burst_done), 32'd1);
        check("clean_done_ready", 32'(ready), 32'd0);
        drain();
        check("clean_seq_err", 32'(seq_err), 32'd0);

        // Backpressure
        do_reset();
        for (int w = 1; w <= BURST_LEN; w++) send_word(DATA_W'(w), 1'b0);
        send_word(32'd1, 1'b0);
        check("bp_full_ready", 32'(ready), 32'd0);
        cycle(1'b1, 32'd2, 1'b0);
        check("bp_held_ready", 32'(ready), 32'd0);
        cycle(1'b1, 32'd2, 1'b1);
        check("bp_ready_rise", 32'(ready), 32'd1);
        check("bp_head_after_pop", out_data, 32'd2);
        send_word(32'd2, 1'b0);
        drain();

        // Sequence error
        do_reset();
        for (int i = 0; i < 3; i++) send_word(bad[i], 1'b1);
        check("seqerr_rise", 32'(seq_err), 32'd1);
        for (int i = 3; i < 7; i++) send_word(bad[i], 1'b1);
        check("seqerr_sum", sum, 32'd29);
        check("seqerr_cnt", 32'(burst_cnt), 32'd1);
        drain();
        check("seqerr_sticky", 32'(seq_err), 32'd1);

        // Sparse valid with idle zeros
        do_reset();
        for (int w = 1; w <= BURST_LEN; w++) begin
            send_word(DATA_W'(w), 1'b1);
            cycle(1'b0, '0, 1'b1);
        end
        check("sparse_sum", sum, 32'd28);
        check("sparse_seq_err", 32'(seq_err), 32'd0);

        // Reset mid-burst
        do_reset();
        for (int w = 1; w <= 3; w++) send_word(DATA_W'(w), 1'b0);
        do_reset();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        for (int w = 1; w <= BURST_LEN; w++) send_word(DATA_W'(w), 1'b0);
        check("midrst_cnt", 32'(burst_cnt), 32'd1);
        check("midrst_sum", sum, 32'd28);
        drain();

        // Randomized traffic with occasional bad words
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            bit v = ($urandom_range(0, 3) != 0);
            logic [DATA_W-1:0] d;
            if (!v) d = $urandom();
            else if ($urandom_range(0, 31) == 0) d = $urandom_range(0, 9);
            else d = DATA_W'(m_pos + 1);
            cycle(v, d, ($urandom_range(0, 2) != 0));
        end
        drain();

        // Continuous streaming over 100 bursts (pointer wrap)
        do_reset();
        guard = 0;
        while (m_cnt < 16'd100 && guard < 3000) begin
            cycle(1'b1, DATA_W'(m_pos + 1), ($urandom_range(0, 3) != 0));
            guard++;
        end
        check("stream_bursts", 32'(burst_cnt), 32'd100);
        check("stream_seq_err", 32'(seq_err), 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
